// File: rtl/pll_rst_pkg.sv
// pll_rst_pkg: state encodings and default cycle constants shared by the
// PLL reset sequencer and its bench/integration code.
package pll_rst_pkg;

    typedef enum logic [1:0] {
        ST_PLL_RST   = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABLE    = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT  = 65535;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_CNT_W         = 17;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic two-flop synchronizer for single-bit (or independent
// multi-bit) signals crossing into the i_clk domain.
//   i_clk    destination clock
//   i_rst_n  asynchronous active-low reset, clears both stages to 0
//   i_d      asynchronous input
//   o_q      synchronized output, two i_clk cycles of latency
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_rst_ctrl.sv
// pll_rst_ctrl: PLL reset sequencer and lock supervisor.
// Holds the PLL in reset for RST_CYCLES, waits up to LOCK_TIMEOUT cycles for
// lock, requires STABLE_CYCLES of continuous lock, then releases the system
// reset. Lock loss, lock timeout or REARM_IN restart the sequence.
//   CLKIN1_IN       free-running reference clock
//   RST_N_IN        asynchronous active-low reset
//   LOCKED_IN       PLL lock (asynchronous, synchronized internally)
//   REARM_IN        synchronous request to re-run the PLL reset
//   PLL_RST_OUT     active-high PLL reset
//   SYS_RST_N_OUT   active-low system reset, high only in RUN
//   LOCK_LOST_OUT   one-cycle pulse on lock loss in RUN
//   TIMEOUT_OUT     one-cycle pulse on lock wait timeout
//   RELOCK_CNT_OUT  saturating count of re-arm events
//   STATE_OUT       current state encoding
module pll_rst_ctrl
    import pll_rst_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic       CLKIN1_IN,
    input  logic       RST_N_IN,
    input  logic       LOCKED_IN,
    input  logic       REARM_IN,
    output logic       PLL_RST_OUT,
    output logic       SYS_RST_N_OUT,
    output logic       LOCK_LOST_OUT,
    output logic       TIMEOUT_OUT,
    output logic [7:0] RELOCK_CNT_OUT,
    output logic [1:0] STATE_OUT
);

    localparam longint CNT_RANGE = longint'(1) << CNT_W;

    if (RST_CYCLES < 1 || longint'(RST_CYCLES) > CNT_RANGE ||
        LOCK_TIMEOUT < 1 || longint'(LOCK_TIMEOUT) > CNT_RANGE ||
        STABLE_CYCLES < 1 || longint'(STABLE_CYCLES) > CNT_RANGE) begin : g_param_err
        $error("pll_rst_ctrl: cycle parameters must lie in 1 .. 2**CNT_W");
    end

    localparam logic [CNT_W-1:0] C_RST_LOAD    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_TO_LOAD     = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_STABLE_LOAD = CNT_W'(STABLE_CYCLES - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_lock_s;
    logic             w_cnt_zero;

    logic             r_pll_rst;
    logic             r_sys_rst_n;
    logic             r_lock_lost;
    logic             r_timeout;
    logic [7:0]       r_relock_cnt;

    logic             w_pll_rst_nxt;
    logic             w_sys_rst_n_nxt;
    logic             w_lock_lost_nxt;
    logic             w_timeout_nxt;
    logic             w_relock_evt;
    logic [7:0]       w_relock_cnt_nxt;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .i_clk   (CLKIN1_IN),
        .i_rst_n (RST_N_IN),
        .i_d     (LOCKED_IN),
        .o_q     (w_lock_s)
    );

    assign w_cnt_zero = (r_cnt == '0);

    // State register; outputs are registered from next-state values so they
    // change in the same cycle as STATE_OUT.
    always_ff @(posedge CLKIN1_IN or negedge RST_N_IN) begin
        if (!RST_N_IN) begin
            r_state      <= ST_PLL_RST;
            r_cnt        <= C_RST_LOAD;
            r_pll_rst    <= 1'b1;
            r_sys_rst_n  <= 1'b0;
            r_lock_lost  <= 1'b0;
            r_timeout    <= 1'b0;
            r_relock_cnt <= '0;
        end else begin
            r_state      <= w_next_state;
            r_cnt        <= w_cnt_nxt;
            r_pll_rst    <= w_pll_rst_nxt;
            r_sys_rst_n  <= w_sys_rst_n_nxt;
            r_lock_lost  <= w_lock_lost_nxt;
            r_timeout    <= w_timeout_nxt;
            r_relock_cnt <= w_relock_cnt_nxt;
        end
    end

    // Next state and shared down-counter. REARM_IN overrides everything,
    // including in PLL_RST where it keeps reloading the reset count.
    always_comb begin
        w_next_state = r_state;
        w_cnt_nxt    = r_cnt - CNT_W'(1);
        if (REARM_IN) begin
            w_next_state = ST_PLL_RST;
            w_cnt_nxt    = C_RST_LOAD;
        end else begin
            case (r_state)
                ST_PLL_RST: begin
                    if (w_cnt_zero) begin
                        w_next_state = ST_WAIT_LOCK;
                        w_cnt_nxt    = C_TO_LOAD;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (w_lock_s) begin
                        w_next_state = ST_STABLE;
                        w_cnt_nxt    = C_STABLE_LOAD;
                    end else if (w_cnt_zero) begin
                        w_next_state = ST_PLL_RST;
                        w_cnt_nxt    = C_RST_LOAD;
                    end
                end
                ST_STABLE: begin
                    if (!w_lock_s) begin
                        w_next_state = ST_WAIT_LOCK;
                        w_cnt_nxt    = C_TO_LOAD;
                    end else if (w_cnt_zero) begin
                        w_next_state = ST_RUN;
                        w_cnt_nxt    = '0;
                    end
                end
                default: begin
                    w_cnt_nxt = '0;
                    if (!w_lock_s) begin
                        w_next_state = ST_PLL_RST;
                        w_cnt_nxt    = C_RST_LOAD;
                    end
                end
            endcase
        end
    end

    // Output decode. Pulses are suppressed when REARM_IN wins the cycle, so
    // only one re-arm cause is ever counted per cycle.
    always_comb begin
        w_pll_rst_nxt    = (w_next_state == ST_PLL_RST);
        w_sys_rst_n_nxt  = (w_next_state == ST_RUN);
        w_lock_lost_nxt  = !REARM_IN && (r_state == ST_RUN) && !w_lock_s;
        w_timeout_nxt    = !REARM_IN && (r_state == ST_WAIT_LOCK) && !w_lock_s && w_cnt_zero;
        w_relock_evt     = (REARM_IN && (r_state != ST_PLL_RST)) || w_lock_lost_nxt || w_timeout_nxt;
        w_relock_cnt_nxt = r_relock_cnt;
        if (w_relock_evt && (r_relock_cnt != 8'hFF)) begin
            w_relock_cnt_nxt = r_relock_cnt + 8'd1;
        end
    end

    assign PLL_RST_OUT    = r_pll_rst;
    assign SYS_RST_N_OUT  = r_sys_rst_n;
    assign LOCK_LOST_OUT  = r_lock_lost;
    assign TIMEOUT_OUT    = r_timeout;
    assign RELOCK_CNT_OUT = r_relock_cnt;
    assign STATE_OUT      = r_state;

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// tb_pll_rst_ctrl: directed bench for pll_rst_ctrl with RST_CYCLES=4,
// STABLE_CYCLES=8, LOCK_TIMEOUT=32. Inputs change and outputs are sampled on
// the falling clock edge; edge_n counts rising edges since reset release.
module tb_pll_rst_ctrl;

    logic       clk;
    logic       rst_n;
    logic       locked;
    logic       rearm;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       lock_lost;
    logic       timeout;
    logic [7:0] relock_cnt;
    logic [1:0] state;

    int n_checks = 0;
    int n_errors = 0;
    int edge_n   = 0;

    pll_rst_ctrl #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (32),
        .STABLE_CYCLES (8),
        .CNT_W         (17)
    ) dut (
        .CLKIN1_IN      (clk),
        .RST_N_IN       (rst_n),
        .LOCKED_IN      (locked),
        .REARM_IN       (rearm),
        .PLL_RST_OUT    (pll_rst),
        .SYS_RST_N_OUT  (sys_rst_n),
        .LOCK_LOST_OUT  (lock_lost),
        .TIMEOUT_OUT    (timeout),
        .RELOCK_CNT_OUT (relock_cnt),
        .STATE_OUT      (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the falling edge after rising edge number e.
    task automatic to_edge(input int e);
        while (edge_n < e) begin
            @(negedge clk);
            edge_n++;
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        locked = 1'b0;
        rearm  = 1'b0;
        #12;
        chk("rst_state",   state, 2'd0);
        chk("rst_pll",     pll_rst, 1'b1);
        chk("rst_sys",     sys_rst_n, 1'b0);
        chk("rst_relock",  relock_cnt, 8'd0);
        chk("rst_lost",    lock_lost, 1'b0);
        chk("rst_timeout", timeout, 1'b0);
        @(negedge clk);
        rst_n  = 1'b1;
        edge_n = 0;

        // Power-up with lock raised before edge 10
        to_edge(3);  chk("pu_pll_e3", pll_rst, 1'b1); chk("pu_st_e3", state, 2'd0);
        to_edge(4);  chk("pu_pll_e4", pll_rst, 1'b0); chk("pu_st_e4", state, 2'd1);
        to_edge(9);  locked = 1'b1;
        to_edge(11); chk("pu_st_e11", state, 2'd1);
        to_edge(12); chk("pu_st_e12", state, 2'd2);
        to_edge(19); chk("pu_st_e19", state, 2'd2); chk("pu_sys_e19", sys_rst_n, 1'b0);
        to_edge(20); chk("pu_st_e20", state, 2'd3); chk("pu_sys_e20", sys_rst_n, 1'b1);
        chk("pu_relock", relock_cnt, 8'd0);

        // One-cycle lock drop in RUN
        locked = 1'b0;
        to_edge(21); locked = 1'b1;
        to_edge(22); chk("ll_st_e22", state, 2'd3); chk("ll_sys_e22", sys_rst_n, 1'b1);
        to_edge(23);
        chk("ll_st_e23", state, 2'd0);    chk("ll_sys_e23", sys_rst_n, 1'b0);
        chk("ll_lost_e23", lock_lost, 1'b1); chk("ll_pll_e23", pll_rst, 1'b1);
        chk("ll_relock", relock_cnt, 8'd1);
        to_edge(24); chk("ll_lost_e24", lock_lost, 1'b0);
        to_edge(26); chk("ll_pll_e26", pll_rst, 1'b1);
        to_edge(27); chk("ll_pll_e27", pll_rst, 1'b0); chk("ll_st_e27", state, 2'd1);
        to_edge(28); chk("ll_st_e28", state, 2'd2);

        // One-cycle lock drop during STABLE
        locked = 1'b0;
        to_edge(29); locked = 1'b1;
        to_edge(30); chk("gl_st_e30", state, 2'd2);
        to_edge(31);
        chk("gl_st_e31", state, 2'd1); chk("gl_relock", relock_cnt, 8'd1);
        chk("gl_lost", lock_lost, 1'b0); chk("gl_timeout", timeout, 1'b0);
        to_edge(32); chk("gl_st_e32", state, 2'd2);
        to_edge(39); chk("gl_st_e39", state, 2'd2);
        to_edge(40); chk("gl_st_e40", state, 2'd3);

        // REARM pulse in RUN
        rearm = 1'b1;
        to_edge(41); rearm = 1'b0;
        chk("ra_st_e41", state, 2'd0); chk("ra_relock", relock_cnt, 8'd2);
        chk("ra_pll_e41", pll_rst, 1'b1); chk("ra_sys_e41", sys_rst_n, 1'b0);
        chk("ra_lost_e41", lock_lost, 1'b0);
        to_edge(54); chk("ra_st_e54", state, 2'd3);

        // REARM held 10 cycles, first seen together with lock loss
        locked = 1'b0;
        to_edge(56); chk("rh_st_e56", state, 2'd3);
        rearm  = 1'b1;
        locked = 1'b1;
        to_edge(57);
        chk("rh_st_e57", state, 2'd0); chk("rh_relock_e57", relock_cnt, 8'd3);
        chk("rh_lost_e57", lock_lost, 1'b0);
        to_edge(66); rearm = 1'b0;
        chk("rh_pll_e66", pll_rst, 1'b1); chk("rh_relock_e66", relock_cnt, 8'd3);
        to_edge(69); chk("rh_pll_e69", pll_rst, 1'b1);
        to_edge(70); chk("rh_pll_e70", pll_rst, 1'b0); chk("rh_st_e70", state, 2'd1);

        // Restart without lock for the timeout sequence
        locked = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("ar1_state", state, 2'd0); chk("ar1_pll", pll_rst, 1'b1);
        chk("ar1_relock", relock_cnt, 8'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        edge_n = 0;

        to_edge(35);  chk("to_st_e35", state, 2'd1); chk("to_pulse_e35", timeout, 1'b0);
        to_edge(36);
        chk("to_st_e36", state, 2'd0); chk("to_pulse_e36", timeout, 1'b1);
        chk("to_relock1", relock_cnt, 8'd1); chk("to_sys_e36", sys_rst_n, 1'b0);
        to_edge(37);  chk("to_pulse_e37", timeout, 1'b0);
        to_edge(72);  chk("to_pulse_e72", timeout, 1'b1); chk("to_relock2", relock_cnt, 8'd2);
        to_edge(108); chk("to_relock3", relock_cnt, 8'd3);
        to_edge(9144); chk("to_relock254", relock_cnt, 8'd254);
        to_edge(9180); chk("to_relock255", relock_cnt, 8'd255); chk("to_pulse255", timeout, 1'b1);
        to_edge(9216); chk("to_sat256", relock_cnt, 8'd255); chk("to_pulse256", timeout, 1'b1);
        to_edge(10800); chk("to_sat300", relock_cnt, 8'd255); chk("to_sys300", sys_rst_n, 1'b0);
        to_edge(10810); chk("to_st_mid", state, 2'd1);

        // Async reset mid-WAIT_LOCK, away from any clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("ar2_state", state, 2'd0);   chk("ar2_pll", pll_rst, 1'b1);
        chk("ar2_sys", sys_rst_n, 1'b0); chk("ar2_relock", relock_cnt, 8'd0);
        chk("ar2_timeout", timeout, 1'b0); chk("ar2_lost", lock_lost, 1'b0);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
